// File: rtl/reaction_ms_counter_pkg.sv
// +----------------------------------------------------------------------+
// | reaction_pkg : shared constants for the reaction-timer ms counter    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package reaction_pkg;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_RUN      = 2'd1;
   localparam logic [1:0] ST_HOLD     = 2'd2;

   localparam logic [3:0] BCD_MAX     = 4'd9;
   localparam int         DIV_DEFAULT = 50000;
   localparam int         NDIG        = 4;

endpackage

`default_nettype wire

// File: rtl/reaction_ms_counter_bcd_digit.sv
// +----------------------------------------------------------------------+
// | bcd_digit : single decade counter with synchronous clear/zero        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_digit
   import reaction_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clr,
   input  logic       zero,
   input  logic       en,
   output logic [3:0] q,
   output logic       carry
);

   logic [3:0] q_q;
   logic [3:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr || zero) begin
         q_d = 4'd0;
      end else if (en) begin
         q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_q <= 4'd0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q     = q_q;
   assign carry = en & (q_q == BCD_MAX);

endmodule

`default_nettype wire

// File: rtl/reaction_ms_counter.sv
// +----------------------------------------------------------------------+
// | reaction_ms_counter : measures start->stop interval in BCD ms        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module reaction_ms_counter
   import reaction_pkg::*;
#(
   parameter int DIV = DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start_clock,
   input  logic       stop_clock,
   input  logic       clr,
   output logic [3:0] bcd0,
   output logic [3:0] bcd1,
   output logic [3:0] bcd2,
   output logic [3:0] bcd3,
   output logic       busy,
   output logic       done_pulse,
   output logic       ovf,
   output logic       false_start
);

   localparam int          PW        = $clog2(DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          start_dly_q, start_dly_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          ovf_q, ovf_d;
   logic          fs_q, fs_d;

   logic          start_rise;
   logic          ms_tick;
   logic          all_nines;
   logic          inc;
   logic          dig_zero;
   logic [3:0]    digit_q [NDIG];
   logic [NDIG-1:0] carry;
   logic [NDIG-1:0] dig_en;
   logic          unused_carry;

   assign start_rise = start_clock & ~start_dly_q;
   assign ms_tick    = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

   always_comb begin
      all_nines = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
         if (digit_q[i] != BCD_MAX) all_nines = 1'b0;
      end
   end

   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      ovf_d       = ovf_q;
      fs_d        = fs_q;
      done_d      = 1'b0;
      inc         = 1'b0;
      dig_zero    = 1'b0;
      start_dly_d = start_clock;
      if (clr) begin
         state_d = ST_IDLE;
         presc_d = '0;
         ovf_d   = 1'b0;
         fs_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_rise) begin
                  state_d  = ST_RUN;
                  presc_d  = '0;
                  dig_zero = 1'b1;
                  ovf_d    = 1'b0;
                  fs_d     = 1'b0;
               end else if (stop_clock && !start_clock) begin
                  fs_d = 1'b1;
               end
            end
            ST_RUN: begin
               presc_d = ms_tick ? '0 : presc_q + PW'(1);
               // Stop outranks a coincident tick so the reading is truncated.
               if (stop_clock) begin
                  state_d = ST_HOLD;
                  done_d  = 1'b1;
               end else if (ms_tick && all_nines) begin
                  state_d = ST_HOLD;
                  ovf_d   = 1'b1;
                  done_d  = 1'b1;
               end else if (!start_clock) begin
                  state_d  = ST_IDLE;
                  presc_d  = '0;
                  dig_zero = 1'b1;
               end else begin
                  inc = ms_tick;
               end
            end
            ST_HOLD: begin
               if (!start_clock) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      busy_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         presc_q     <= '0;
         start_dly_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
         fs_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         start_dly_q <= start_dly_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
         fs_q        <= fs_d;
      end
   end

   for (genvar i = 0; i < NDIG; i++) begin : g_digit
      if (i == 0) begin : g_lsd
         assign dig_en[i] = inc;
      end else begin : g_upper
         assign dig_en[i] = carry[i-1];
      end
      bcd_digit u_digit (
         .clk     (clk),
         .reset_n (reset_n),
         .clr     (clr),
         .zero    (dig_zero),
         .en      (dig_en[i]),
         .q       (digit_q[i]),
         .carry   (carry[i])
      );
   end

   // Saturation is handled before the chain, so the top carry never fires.
   assign unused_carry = carry[NDIG-1];

   assign bcd0        = digit_q[0];
   assign bcd1        = digit_q[1];
   assign bcd2        = digit_q[2];
   assign bcd3        = digit_q[3];
   assign busy        = busy_q;
   assign done_pulse  = done_q;
   assign ovf         = ovf_q;
   assign false_start = fs_q;

endmodule

`default_nettype wire
